cdb_arbiter: RTL and testbench

//  Completion side of the RS/FU interface. Collects finished results from the NUM_FU functional units.

---
 rtl/cdb_arbiter_pkg.sv | 34 +++
 rtl/cdb_arbiter_rr_arbiter.sv | 34 +++
 rtl/cdb_arbiter.sv | 118 +++++++++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the completion path: FU results, CDB broadcast, done vector.
package sys_defs;

    localparam int unsigned NUM_RS    = 6;
    localparam int unsigned NUM_FU    = NUM_RS;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_TAG_W = 5;
    // Wide enough to hold FU ids 0..NUM_RS; id 0 means "none".
    localparam int unsigned RR_IDX_W  = $clog2(NUM_RS + 1);

    typedef logic [ROB_TAG_W-1:0] ROB_TAG;

    // Tag 0 marks "no producer"; never broadcast while the CDB is valid.
    localparam ROB_TAG ZERO_REG = '0;

    typedef struct packed {
        ROB_TAG            rob_tag;
        logic [XLEN-1:0]   v;
    } CDB_PACKET;

    typedef logic [NUM_RS:0] FU_DONE_PACKET;

    typedef struct packed {
        logic              valid;
        ROB_TAG            rob_tag;
        logic [XLEN-1:0]   v;
    } FU_RESULT_PACKET;

    // One-hot done vector for a granted FU id (bit 0 stays clear for id >= 1).
    function automatic FU_DONE_PACKET fu_onehot(input logic [RR_IDX_W-1:0] idx);
        return FU_DONE_PACKET'(1) << idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after the pointer, wrapping N..1.
module rr_arbiter #(
    parameter int unsigned N     = 6,
    parameter int unsigned IDX_W = $clog2(N + 1)
) (
    input  logic [N:1]       i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N:1]       o_grant_c,
    output logic [IDX_W-1:0] o_grant_idx_c,
    output logic             o_grant_valid_c
);

    int unsigned w_cand;

    // Scan ptr+1..N then 1..ptr; the first requester found wins.
    always_comb begin
        o_grant_c       = '0;
        o_grant_idx_c   = '0;
        o_grant_valid_c = 1'b0;
        w_cand          = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = 32'(i_ptr) + k;
            if (w_cand > N) begin
                w_cand = w_cand - N;
            end
            if (!o_grant_valid_c && i_req[IDX_W'(w_cand)]) begin
                o_grant_valid_c             = 1'b1;
                o_grant_idx_c               = IDX_W'(w_cand);
                o_grant_c[IDX_W'(w_cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-side CDB arbiter: buffers one result per FU, broadcasts one per cycle round-robin,
// and pulses the matching fu_done bit so the RS can free its entry.
module cdb_arbiter
    import sys_defs::*;
(
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             squash,
    input  logic [NUM_FU:1]                  fu_result_valid,
    input  logic [NUM_FU:1][ROB_TAG_W-1:0]   fu_result_tag,
    input  logic [NUM_FU:1][XLEN-1:0]        fu_result_value,
    output logic [NUM_FU:1]                  fu_stall,
    output logic                             cdb_valid,
    output logic [ROB_TAG_W-1:0]             cdb_rob_tag,
    output logic [XLEN-1:0]                  cdb_v,
    output logic [NUM_FU:0]                  fu_done
);

    logic [NUM_FU:1]                 w_full;
    logic [NUM_FU:1][ROB_TAG_W-1:0]  w_buf_tag;
    logic [NUM_FU:1][XLEN-1:0]       w_buf_val;
    logic [NUM_FU:1]                 w_grant;
    logic [NUM_FU:1]                 w_accept;
    logic [RR_IDX_W-1:0]             w_grant_idx;
    logic                            w_grant_valid;

    logic [RR_IDX_W-1:0]             r_rr_ptr;
    logic                            r_cdb_valid;
    CDB_PACKET                       r_cdb;
    FU_DONE_PACKET                   r_fu_done;

    rr_arbiter #(
        .N      (NUM_FU),
        .IDX_W  (RR_IDX_W)
    ) u_rr (
        .i_req            (w_full),
        .i_ptr            (r_rr_ptr),
        .o_grant_c        (w_grant),
        .o_grant_idx_c    (w_grant_idx),
        .o_grant_valid_c  (w_grant_valid)
    );

    for (genvar i = 1; i <= NUM_FU; i++) begin : gen_fu
        FU_RESULT_PACKET w_in;
        FU_RESULT_PACKET r_entry;

        assign w_in = '{valid: fu_result_valid[i], rob_tag: fu_result_tag[i], v: fu_result_value[i]};

        // A full buffer blocks its FU unless it drains this cycle; squash releases everyone.
        assign fu_stall[i] = !squash && r_entry.valid && !w_grant[i];
        assign w_accept[i] = !squash && w_in.valid && !fu_stall[i];

        assign w_full[i]    = r_entry.valid;
        assign w_buf_tag[i] = r_entry.rob_tag;
        assign w_buf_val[i] = r_entry.v;

        // Hold buffer: refill takes priority over drain so a granted FU streams without a bubble.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_entry <= '0;
            end else if (squash) begin
                r_entry <= '0;
            end else if (w_accept[i]) begin
                r_entry <= w_in;
            end else if (w_grant[i]) begin
                r_entry <= '0;
            end
        end

        a_tag_nonzero: assert property (@(posedge clock) disable iff (!reset_n)
            fu_result_valid[i] |-> (fu_result_tag[i] != ZERO_REG));

        a_hold_stable: assert property (@(posedge clock) disable iff (!reset_n)
            (fu_result_valid[i] && fu_stall[i]) |=>
            (fu_result_valid[i] && $stable(fu_result_tag[i]) && $stable(fu_result_value[i])));
    end

    // Round-robin pointer follows the last winner; a squash leaves it untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= RR_IDX_W'(NUM_FU);
        end else if (!squash && w_grant_valid) begin
            r_rr_ptr <= w_grant_idx;
        end
    end

    // Registered CDB broadcast and done pulse; zeroed whenever nothing is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb       <= '0;
            r_fu_done   <= '0;
        end else if (squash || !w_grant_valid) begin
            r_cdb_valid <= 1'b0;
            r_cdb       <= '0;
            r_fu_done   <= '0;
        end else begin
            r_cdb_valid <= 1'b1;
            r_cdb       <= '{rob_tag: w_buf_tag[w_grant_idx], v: w_buf_val[w_grant_idx]};
            r_fu_done   <= fu_onehot(w_grant_idx);
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_rob_tag = r_cdb.rob_tag;
    assign cdb_v       = r_cdb.v;
    assign fu_done     = r_fu_done;

    a_done_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(fu_done));

    a_done_needs_valid: assert property (@(posedge clock) disable iff (!reset_n)
        (|fu_done) |-> cdb_valid);

    a_done_bit0_clear: assert property (@(posedge clock) disable iff (!reset_n)
        !fu_done[0]);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, streaming, same-cycle refill,
// squash and asynchronous reset.
module tb_cdb_arbiter;
    import sys_defs::*;

    logic                            clock;
    logic                            reset_n;
    logic                            squash;
    logic [NUM_FU:1]                 fu_result_valid;
    logic [NUM_FU:1][ROB_TAG_W-1:0]  fu_result_tag;
    logic [NUM_FU:1][XLEN-1:0]       fu_result_value;
    logic [NUM_FU:1]                 fu_stall;
    logic                            cdb_valid;
    logic [ROB_TAG_W-1:0]            cdb_rob_tag;
    logic [XLEN-1:0]                 cdb_v;
    logic [NUM_FU:0]                 fu_done;

    int n_checks;
    int n_pass;

    cdb_arbiter u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .squash          (squash),
        .fu_result_valid (fu_result_valid),
        .fu_result_tag   (fu_result_tag),
        .fu_result_value (fu_result_value),
        .fu_stall        (fu_stall),
        .cdb_valid       (cdb_valid),
        .cdb_rob_tag     (cdb_rob_tag),
        .cdb_v           (cdb_v),
        .fu_done         (fu_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic v, input logic [4:0] t,
                             input logic [31:0] val, input logic [6:0] done);
        check_eq({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        check_eq({tag, "_tag"},   64'(cdb_rob_tag), 64'(t));
        check_eq({tag, "_v"},     64'(cdb_v), 64'(val));
        check_eq({tag, "_done"},  64'(fu_done), 64'(done));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        squash          = 1'b0;
        fu_result_valid = '0;
        fu_result_tag   = '0;
        fu_result_value = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    int               seq [1:6];
    int               cnt [1:6];
    logic [31:0]      exp_q [1:6][$];
    logic [31:0]      expv;
    logic [6:0]       expd;
    int               nb;
    int               exp_id;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        clear_inputs();
        #3;
        check_cdb("reset", 1'b0, 5'd0, 32'd0, 7'd0);
        check_eq("reset_stall", 64'(fu_stall), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single result from FU2: visible two edges later, one-cycle pulse.
        fu_result_valid[2] = 1'b1;
        fu_result_tag[2]   = 5'd7;
        fu_result_value[2] = 32'h55;
        tick();
        clear_inputs();
        check_cdb("t1_c2", 1'b0, 5'd0, 32'd0, 7'd0);
        tick();
        check_cdb("t1_c3", 1'b1, 5'd7, 32'h55, 7'b0000100);
        tick();
        check_cdb("t1_c4", 1'b0, 5'd0, 32'd0, 7'd0);

        // FU1, FU3, FU5 together from rr_ptr=6: order 1,3,5 and matching stall lengths.
        do_reset();
        fu_result_valid[1] = 1'b1; fu_result_tag[1] = 5'd3; fu_result_value[1] = 32'h103;
        fu_result_valid[3] = 1'b1; fu_result_tag[3] = 5'd4; fu_result_value[3] = 32'h304;
        fu_result_valid[5] = 1'b1; fu_result_tag[5] = 5'd5; fu_result_value[5] = 32'h505;
        tick();
        clear_inputs();
        #1;
        check_eq("t2_stall_c1", 64'(fu_stall), 64'(6'b010100));
        tick();
        check_cdb("t2_c2", 1'b1, 5'd3, 32'h103, 7'b0000010);
        #1;
        check_eq("t2_stall_c2", 64'(fu_stall), 64'(6'b010000));
        tick();
        check_cdb("t2_c3", 1'b1, 5'd4, 32'h304, 7'b0001000);
        #1;
        check_eq("t2_stall_c3", 64'(fu_stall), 64'd0);
        tick();
        check_cdb("t2_c4", 1'b1, 5'd5, 32'h505, 7'b0100000);
        tick();
        check_cdb("t2_c5", 1'b0, 5'd0, 32'd0, 7'd0);

        // All FUs stream continuously; scoreboard per FU, grant order 1..6 repeating.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            seq[i] = 0;
            cnt[i] = 0;
            exp_q[i].delete();
        end
        nb     = 0;
        exp_id = 1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            if (cdb_valid && nb < 30) begin
                expd = 7'b1 << exp_id;
                check_eq("t3_done", 64'(fu_done), 64'(expd));
                check_eq("t3_tag", 64'(cdb_rob_tag), 64'(exp_id));
                if (exp_q[exp_id].size() > 0) begin
                    expv = exp_q[exp_id].pop_front();
                end else begin
                    expv = 32'hDEADBEEF;
                end
                check_eq("t3_value", 64'(cdb_v), 64'(expv));
                for (int i = 1; i <= 6; i++) begin
                    if (fu_done[i]) cnt[i]++;
                end
                nb++;
                exp_id = (exp_id == 6) ? 1 : exp_id + 1;
            end
            for (int i = 1; i <= 6; i++) begin
                fu_result_valid[i] = 1'b1;
                fu_result_tag[i]   = 5'(i);
                fu_result_value[i] = {16'(i), 16'(seq[i])};
            end
            #1;
            for (int i = 1; i <= 6; i++) begin
                if (!fu_stall[i]) begin
                    exp_q[i].push_back(fu_result_value[i]);
                    seq[i]++;
                end
            end
            tick();
        end
        check_eq("t3_bcasts", 64'(nb), 64'd30);
        for (int i = 1; i <= 6; i++) begin
            check_eq("t3_grant_count", 64'(cnt[i]), 64'd5);
        end

        // FU4 refills in the cycle its buffer is granted: no stall, no bubble.
        do_reset();
        fu_result_valid[4] = 1'b1; fu_result_tag[4] = 5'd8; fu_result_value[4] = 32'h80;
        tick();
        fu_result_tag[4] = 5'd9; fu_result_value[4] = 32'h90;
        #1;
        check_eq("t4_stall", 64'(fu_stall), 64'd0);
        tick();
        clear_inputs();
        check_cdb("t4_first", 1'b1, 5'd8, 32'h80, 7'b0010000);
        tick();
        check_cdb("t4_second", 1'b1, 5'd9, 32'h90, 7'b0010000);
        tick();
        check_cdb("t4_idle", 1'b0, 5'd0, 32'd0, 7'd0);

        // Squash with FU1/FU6 buffered; result presented during squash is dropped; rr_ptr kept.
        do_reset();
        fu_result_valid[1] = 1'b1; fu_result_tag[1] = 5'd2; fu_result_value[1] = 32'h22;
        fu_result_valid[6] = 1'b1; fu_result_tag[6] = 5'd8; fu_result_value[6] = 32'h68;
        tick();
        clear_inputs();
        squash = 1'b1;
        fu_result_valid[3] = 1'b1; fu_result_tag[3] = 5'd10; fu_result_value[3] = 32'hA0;
        #1;
        check_eq("t5_stall_squash", 64'(fu_stall), 64'd0);
        tick();
        clear_inputs();
        check_cdb("t5_after", 1'b0, 5'd0, 32'd0, 7'd0);
        fu_result_valid[1] = 1'b1; fu_result_tag[1] = 5'd12; fu_result_value[1] = 32'hC1;
        fu_result_valid[6] = 1'b1; fu_result_tag[6] = 5'd13; fu_result_value[6] = 32'hD6;
        tick();
        clear_inputs();
        check_cdb("t5_empty", 1'b0, 5'd0, 32'd0, 7'd0);
        tick();
        check_cdb("t5_fu1", 1'b1, 5'd12, 32'hC1, 7'b0000010);
        tick();
        check_cdb("t5_fu6", 1'b1, 5'd13, 32'hD6, 7'b1000000);
        tick();
        check_cdb("t5_idle", 1'b0, 5'd0, 32'd0, 7'd0);

        // Asynchronous reset mid-broadcast clears outputs before the next edge.
        do_reset();
        fu_result_valid[5] = 1'b1; fu_result_tag[5] = 5'd12; fu_result_value[5] = 32'hAB;
        tick();
        clear_inputs();
        tick();
        check_cdb("t6_pre", 1'b1, 5'd12, 32'hAB, 7'b0100000);
        #2;
        reset_n = 1'b0;
        #1;
        check_cdb("t6_async", 1'b0, 5'd0, 32'd0, 7'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        check_cdb("t6_post", 1'b0, 5'd0, 32'd0, 7'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
